// File: rtl/boot_run_ctrl_pkg.sv
// Shared types and default widths for the boot-and-run sequencer.
package boot_run_ctrl_pkg;

    localparam int unsigned ADDR_W_DEF     = 6;
    localparam int unsigned DATA_W_DEF     = 32;
    localparam int unsigned CYC_W_DEF      = 16;
    localparam int unsigned RST_CYCLES_DEF = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } state_e;

endpackage

// File: rtl/boot_run_ctrl_if.sv
// Harness-side bundle: program load stream, imem write port, processor controls, status.
interface boot_run_ctrl_if
    import boot_run_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned CYC_W  = CYC_W_DEF
);
    logic              start;
    logic              ld_valid;
    logic              ld_ready;
    logic [DATA_W-1:0] ld_data;
    logic              ld_last;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [DATA_W-1:0] imem_wdata;
    logic              proc_reset;
    logic              proc_run;
    logic              halt_req;
    logic [CYC_W-1:0]  cycle_budget;
    logic [CYC_W-1:0]  cycles;
    logic              done;
    logic              err;

    modport master (
        output start, ld_valid, ld_data, ld_last, halt_req, cycle_budget,
        input  ld_ready, imem_we, imem_addr, imem_wdata, proc_reset, proc_run,
               cycles, done, err
    );

    modport slave (
        input  start, ld_valid, ld_data, ld_last, halt_req, cycle_budget,
        output ld_ready, imem_we, imem_addr, imem_wdata, proc_reset, proc_run,
               cycles, done, err
    );

endinterface

// File: rtl/boot_run_ctrl_run_counter.sv
// Reset-phase down-counter plus executed-cycle up-counter with budget compare.
module boot_run_ctrl_run_counter #(
    parameter int unsigned CYC_W      = 16,
    parameter int unsigned RST_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             en,
    input  logic [CYC_W-1:0] budget,
    output logic             in_reset,
    output logic             hit,
    output logic [CYC_W-1:0] count
);
    localparam int unsigned RST_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

    logic [RST_W-1:0] rst_cnt_q, rst_cnt_d;
    logic             in_reset_q, in_reset_d;
    logic [CYC_W-1:0] count_q, count_d;
    logic [CYC_W-1:0] budget_q, budget_d;

    always_comb begin
        rst_cnt_d  = rst_cnt_q;
        in_reset_d = in_reset_q;
        count_d    = count_q;
        budget_d   = budget_q;
        if (clear) begin
            rst_cnt_d  = RST_W'(RST_CYCLES - 1);
            in_reset_d = 1'b1;
            count_d    = '0;
            budget_d   = budget;
        end else if (en) begin
            if (in_reset_q) begin
                if (rst_cnt_q == '0) in_reset_d = 1'b0;
                else                 rst_cnt_d  = rst_cnt_q - RST_W'(1);
            end else begin
                count_d = count_q + CYC_W'(1);
            end
        end
    end

    // Fires in the cycle whose completion makes count reach the budget,
    // so the run stops after exactly budget executed cycles.
    always_comb begin
        if (in_reset_q) hit = en && (rst_cnt_q == '0) && (budget_q == '0);
        else            hit = en && ((count_q + CYC_W'(1)) == budget_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_cnt_q  <= '0;
            in_reset_q <= 1'b0;
            count_q    <= '0;
            budget_q   <= '0;
        end else begin
            rst_cnt_q  <= rst_cnt_d;
            in_reset_q <= in_reset_d;
            count_q    <= count_d;
            budget_q   <= budget_d;
        end
    end

    assign in_reset = in_reset_q;
    assign count    = count_q;

endmodule

// File: rtl/boot_run_ctrl.sv
// Boot-and-run sequencer: streams a program into imem, then resets, runs and freezes the core.
module boot_run_ctrl
    import boot_run_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W     = ADDR_W_DEF,
    parameter int unsigned DATA_W     = DATA_W_DEF,
    parameter int unsigned CYC_W      = CYC_W_DEF,
    parameter int unsigned RST_CYCLES = RST_CYCLES_DEF
) (
    input  logic           clk,
    input  logic           reset,
    boot_run_ctrl_if.slave bus
);
    localparam logic [ADDR_W-1:0] PTR_MAX = '1;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              we_q, we_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    logic              start_ok;
    logic              rc_in_reset;
    logic              rc_hit;
    logic [CYC_W-1:0]  rc_count;

    assign start_ok = bus.start && ((state_q == ST_IDLE) || (state_q == ST_DONE));

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        we_d    = 1'b0;
        done_d  = done_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start_ok) begin
                    state_d = ST_LOAD;
                    ptr_d   = '0;
                    done_d  = 1'b0;
                    err_d   = 1'b0;
                end
            end
            ST_LOAD: begin
                if (bus.ld_valid) begin
                    we_d    = 1'b1;
                    addr_d  = ptr_q;
                    wdata_d = bus.ld_data;
                    ptr_d   = ptr_q + ADDR_W'(1);
                    if (bus.ld_last) begin
                        state_d = ST_RUN;
                    end else if (ptr_q == PTR_MAX) begin
                        err_d   = 1'b1;
                        state_d = ST_DONE;
                    end
                end
            end
            ST_RUN: begin
                if (rc_hit || bus.halt_req) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    boot_run_ctrl_run_counter #(
        .CYC_W      (CYC_W),
        .RST_CYCLES (RST_CYCLES)
    ) u_run_counter (
        .clk      (clk),
        .rst_n    (reset),
        .clear    (start_ok),
        .en       (state_q == ST_RUN),
        .budget   (bus.cycle_budget),
        .in_reset (rc_in_reset),
        .hit      (rc_hit),
        .count    (rc_count)
    );

    // Core reset is released only in RUN after the reset phase, and stays
    // released in DONE after a completed run so its state can be inspected.
    assign bus.proc_reset = (state_q == ST_RUN) ? rc_in_reset
                                                : !((state_q == ST_DONE) && done_q);
    assign bus.proc_run   = (state_q == ST_RUN);
    assign bus.ld_ready   = (state_q == ST_LOAD);
    assign bus.imem_we    = we_q;
    assign bus.imem_addr  = addr_q;
    assign bus.imem_wdata = wdata_q;
    assign bus.cycles     = rc_count;
    assign bus.done       = done_q;
    assign bus.err        = err_q;

endmodule

// File: tb/tb_boot_run_ctrl.sv
// Directed bench for boot_run_ctrl with a small imem (ADDR_W=3) to reach the overflow case.
module tb_boot_run_ctrl;

    localparam int unsigned ADDR_W     = 3;
    localparam int unsigned DATA_W     = 32;
    localparam int unsigned CYC_W      = 16;
    localparam int unsigned RST_CYCLES = 2;

    logic clk;
    logic rst_n;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;
    int rel_cnt = 0;

    logic [31:0] log_addr[$];
    logic [31:0] log_data[$];
    int          log_cyc[$];
    logic [31:0] prog[16];

    boot_run_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CYC_W(CYC_W)) bus ();

    boot_run_ctrl #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .CYC_W(CYC_W), .RST_CYCLES(RST_CYCLES)
    ) dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Write and reset-release monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (bus.imem_we === 1'b1) begin
            log_addr.push_back(32'(bus.imem_addr));
            log_data.push_back(bus.imem_wdata);
            log_cyc.push_back(cyc);
        end
        if (bus.proc_reset === 1'b0) rel_cnt <= rel_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [CYC_W-1:0] budget);
        bus.cycle_budget = budget;
        bus.start        = 1'b1;
        tick();
        bus.start        = 1'b0;
    endtask

    // Streams prog[0..n-1], ld_last on the final word, gap idle cycles between words.
    task automatic stream(input int n, input int gap);
        for (int i = 0; i < n; i++) begin
            bus.ld_valid = 1'b1;
            bus.ld_data  = prog[i];
            bus.ld_last  = (i == n - 1);
            tick();
            bus.ld_valid = 1'b0;
            bus.ld_last  = 1'b0;
            if (i != n - 1) repeat (gap) tick();
        end
    endtask

    task automatic wait_done(input int max, output int n);
        n = 0;
        while (bus.done !== 1'b1 && n < max) begin
            tick();
            n++;
        end
    endtask

    task automatic check_log(input string tag, input int base, input int n, input int spacing);
        chk({tag, "_wcount"}, 32'(log_addr.size() - base), 32'(n));
        for (int i = 0; i < n; i++) begin
            if (base + i < log_addr.size()) begin
                chk({tag, "_waddr"}, log_addr[base+i], 32'(i));
                chk({tag, "_wdata"}, log_data[base+i], prog[i]);
                if (i > 0)
                    chk({tag, "_wspace"}, 32'(log_cyc[base+i] - log_cyc[base+i-1]), 32'(spacing));
            end
        end
    endtask

    initial begin
        int n;
        int base;
        int rel0;

        #100000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        int base;
        int rel0;

        rst_n            = 1'b0;
        bus.start        = 1'b0;
        bus.ld_valid     = 1'b0;
        bus.ld_data      = '0;
        bus.ld_last      = 1'b0;
        bus.halt_req     = 1'b0;
        bus.cycle_budget = '0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();

        chk("rst_ld_ready",   32'(bus.ld_ready),   32'd0);
        chk("rst_proc_reset", 32'(bus.proc_reset), 32'd1);
        chk("rst_proc_run",   32'(bus.proc_run),   32'd0);
        chk("rst_imem_we",    32'(bus.imem_we),    32'd0);
        chk("rst_imem_addr",  32'(bus.imem_addr),  32'd0);
        chk("rst_cycles",     32'(bus.cycles),     32'd0);
        chk("rst_done",       32'(bus.done),       32'd0);
        chk("rst_err",        32'(bus.err),        32'd0);

        // Asynchronous reset in the middle of a load.
        do_start(16'd5);
        chk("t1_ld_ready", 32'(bus.ld_ready), 32'd1);
        for (int i = 0; i < 3; i++) begin
            bus.ld_valid = 1'b1;
            bus.ld_data  = 32'h100 + 32'(i);
            tick();
        end
        chk("t1_we_before",   32'(bus.imem_we),   32'd1);
        chk("t1_addr_before", 32'(bus.imem_addr), 32'd2);
        #2 rst_n = 1'b0;
        #1;
        chk("t1_async_proc_reset", 32'(bus.proc_reset), 32'd1);
        chk("t1_async_ld_ready",   32'(bus.ld_ready),   32'd0);
        chk("t1_async_imem_we",    32'(bus.imem_we),    32'd0);
        bus.ld_valid = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        chk("t1_idle_ld_ready", 32'(bus.ld_ready), 32'd0);
        chk("t1_idle_cycles",   32'(bus.cycles),   32'd0);

        // Fibonacci program, budget 100, continuous valid.
        prog[0] = 32'd1; prog[1] = 32'd1; prog[2] = 32'd2;
        prog[3] = 32'd3; prog[4] = 32'd5; prog[5] = 32'd8;
        base = log_addr.size();
        do_start(16'd100);
        stream(6, 0);
        chk("t2_r1_proc_reset", 32'(bus.proc_reset), 32'd1);
        chk("t2_r1_proc_run",   32'(bus.proc_run),   32'd1);
        chk("t2_r1_imem_we",    32'(bus.imem_we),    32'd1);
        tick();
        chk("t2_r2_proc_reset", 32'(bus.proc_reset), 32'd1);
        chk("t2_r2_imem_we",    32'(bus.imem_we),    32'd0);
        tick();
        chk("t2_r3_proc_reset", 32'(bus.proc_reset), 32'd0);
        chk("t2_r3_proc_run",   32'(bus.proc_run),   32'd1);
        chk("t2_r3_cycles",     32'(bus.cycles),     32'd0);
        wait_done(400, n);
        chk("t2_done_latency", 32'(n),              32'd100);
        chk("t2_done",         32'(bus.done),       32'd1);
        chk("t2_cycles",       32'(bus.cycles),     32'd100);
        chk("t2_proc_run_off", 32'(bus.proc_run),   32'd0);
        chk("t2_done_reset",   32'(bus.proc_reset), 32'd0);
        check_log("t2", base, 6, 1);

        // Overflow: 9 words without ld_last into an 8-word imem.
        for (int i = 0; i < 9; i++) prog[i] = 32'hA0 + 32'(i);
        base = log_addr.size();
        do_start(16'd50);
        rel0 = rel_cnt;
        for (int i = 0; i < 9; i++) begin
            bus.ld_valid = 1'b1;
            bus.ld_data  = prog[i];
            bus.ld_last  = 1'b0;
            if (i == 8) chk("t3_ready_word9", 32'(bus.ld_ready), 32'd0);
            tick();
        end
        bus.ld_valid = 1'b0;
        repeat (3) tick();
        check_log("t3", base, 8, 1);
        chk("t3_err",        32'(bus.err),          32'd1);
        chk("t3_done",       32'(bus.done),         32'd0);
        chk("t3_ld_ready",   32'(bus.ld_ready),     32'd0);
        chk("t3_proc_run",   32'(bus.proc_run),     32'd0);
        chk("t3_proc_reset", 32'(bus.proc_reset),   32'd1);
        chk("t3_never_rel",  32'(rel_cnt - rel0),   32'd0);

        // Halt at run cycle 37 with a large budget; reload starts at address 0.
        prog[0] = 32'h11; prog[1] = 32'h22;
        base = log_addr.size();
        do_start(16'd1000);
        chk("t4_err_cleared", 32'(bus.err), 32'd0);
        stream(2, 0);
        n = 0;
        while (bus.cycles != 16'd36 && n < 200) begin
            tick();
            n++;
        end
        chk("t4_reach36", 32'(n), 32'd38);
        bus.halt_req = 1'b1;
        tick();
        bus.halt_req = 1'b0;
        chk("t4_done",     32'(bus.done),     32'd1);
        chk("t4_cycles",   32'(bus.cycles),   32'd37);
        chk("t4_proc_run", 32'(bus.proc_run), 32'd0);
        check_log("t4", base, 2, 1);

        // Halt during the reset phase.
        prog[0] = 32'h33;
        do_start(16'd1000);
        stream(1, 0);
        bus.halt_req = 1'b1;
        tick();
        bus.halt_req = 1'b0;
        chk("t4b_done",     32'(bus.done),     32'd1);
        chk("t4b_cycles",   32'(bus.cycles),   32'd0);
        chk("t4b_proc_run", 32'(bus.proc_run), 32'd0);

        // Budget 0 with a start pulse during RUN that must be ignored.
        prog[0] = 32'h44;
        do_start(16'd0);
        stream(1, 0);
        bus.start = 1'b1;
        n = 0;
        while (bus.proc_run === 1'b1 && n < 50) begin
            n++;
            tick();
            bus.start = 1'b0;
        end
        bus.start = 1'b0;
        chk("t5_run_cycles", 32'(n),          32'd2);
        chk("t5_done",       32'(bus.done),   32'd1);
        chk("t5_cycles",     32'(bus.cycles), 32'd0);

        // Restart from DONE, then a gapped load (1 on, 2 off) with budget 7.
        for (int i = 0; i < 4; i++) prog[i] = 32'hC0DE_0000 + 32'(i);
        base = log_addr.size();
        do_start(16'd7);
        chk("t5_restart_done",   32'(bus.done),       32'd0);
        chk("t5_restart_cycles", 32'(bus.cycles),     32'd0);
        chk("t5_restart_ready",  32'(bus.ld_ready),   32'd1);
        chk("t5_restart_reset",  32'(bus.proc_reset), 32'd1);
        repeat (2) tick();
        stream(4, 2);
        wait_done(100, n);
        chk("t6_done_latency", 32'(n),          32'd9);
        chk("t6_cycles",       32'(bus.cycles), 32'd7);
        repeat (2) tick();
        check_log("t6", base, 4, 3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
